// File: rtl/vec_pkg.sv
// Shared definitions for the vector memory sequencer: state encoding,
// default widths and the index of each address source.
package vec_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;

  // Address sources held by the address generator.
  localparam int NUM_SRC = 3;
  localparam int SRC_A   = 0;
  localparam int SRC_B   = 1;
  localparam int SRC_C   = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_LD_B = 3'd3,
    ST_EXEC = 3'd4,
    ST_WR   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Command/status and memory-control bundle between the decode logic,
// the sequencer and the operand/result register datapath.
interface vec_mem_sequencer_if
  import vec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              start;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_c;
  logic [LEN_W-1:0]  vlen;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              a_we;
  logic              b_we;
  logic              r_we;
  logic [LEN_W-1:0]  elem_idx;
  logic              busy;
  logic              done;

  // Decode side / datapath side.
  modport master (
    output start, base_a, base_b, base_c, vlen,
    input  mem_addr, mem_we, a_we, b_we, r_we, elem_idx, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, base_a, base_b, base_c, vlen,
    output mem_addr, mem_we, a_we, b_we, r_we, elem_idx, busy, done
  );

endinterface

// File: rtl/vec_addr_gen.sv
// Latched base addresses and element index counter; produces the A, B and C
// element addresses (base + index, wrapping modulo 2^ADDR_W).
module vec_addr_gen
  import vec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              inc,
  input  logic              clr,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [LEN_W-1:0]  vlen,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_c,
  output logic [LEN_W-1:0]  idx,
  output logic              last
);

  logic [ADDR_W-1:0] base_in  [NUM_SRC];
  logic [ADDR_W-1:0] addr_out [NUM_SRC];
  logic [LEN_W-1:0]  idx_reg;
  logic [LEN_W-1:0]  vlen_reg;

  assign base_in[SRC_A] = base_a;
  assign base_in[SRC_B] = base_b;
  assign base_in[SRC_C] = base_c;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [ADDR_W-1:0] base_reg;

      always_ff @(posedge clk) begin
        if (srst) begin
          base_reg <= '0;
        end else if (load) begin
          base_reg <= base_in[gi];
        end
      end

      assign addr_out[gi] = base_reg + ADDR_W'(idx_reg);
    end
  endgenerate

  // A new command always starts at element 0; clr returns the index to 0
  // on the way back to IDLE.
  always_ff @(posedge clk) begin
    if (srst) begin
      idx_reg  <= '0;
      vlen_reg <= '0;
    end else begin
      if (load) begin
        vlen_reg <= vlen;
      end
      if (clr || load) begin
        idx_reg <= '0;
      end else if (inc) begin
        idx_reg <= idx_reg + LEN_W'(1);
      end
    end
  end

  assign addr_a = addr_out[SRC_A];
  assign addr_b = addr_out[SRC_B];
  assign addr_c = addr_out[SRC_C];
  assign idx    = idx_reg;
  assign last   = (idx_reg == vlen_reg - LEN_W'(1));

endmodule

// File: rtl/vec_mem_sequencer.sv
// Per-element loop controller: for each vector element reads A and B from
// data memory, strobes the result register and writes the result back.
module vec_mem_sequencer
  import vec_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic                clk,
  input logic                rst,
  vec_mem_sequencer_if.slave bus
);

  state_t state_reg;
  state_t state_next;

  logic              load;
  logic              inc;
  logic              clr;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W-1:0] addr_c;
  logic [LEN_W-1:0]  idx;
  logic              last;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              a_we;
  logic              b_we;
  logic              r_we;
  logic              done;

  vec_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk    (clk),
    .srst   (rst),
    .load   (load),
    .inc    (inc),
    .clr    (clr),
    .base_a (bus.base_a),
    .base_b (bus.base_b),
    .base_c (bus.base_c),
    .vlen   (bus.vlen),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .addr_c (addr_c),
    .idx    (idx),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Outputs decode from the registered state only; start merely steers the
  // next state and the base/length capture.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    inc        = 1'b0;
    clr        = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    r_we       = 1'b0;
    done       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = (bus.vlen != '0) ? ST_RD_A : ST_DONE;
        end
      end
      ST_RD_A: begin
        mem_addr   = addr_a;
        state_next = ST_RD_B;
      end
      ST_RD_B: begin
        // A data from the previous cycle's read is on the memory output now.
        mem_addr   = addr_b;
        a_we       = 1'b1;
        state_next = ST_LD_B;
      end
      ST_LD_B: begin
        mem_addr   = addr_b;
        b_we       = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        r_we       = 1'b1;
        state_next = ST_WR;
      end
      ST_WR: begin
        mem_addr = addr_c;
        mem_we   = 1'b1;
        if (last) begin
          state_next = ST_DONE;
        end else begin
          inc        = 1'b1;
          state_next = ST_RD_A;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        clr        = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_addr = mem_addr;
  assign bus.mem_we   = mem_we;
  assign bus.a_we     = a_we;
  assign bus.b_we     = b_we;
  assign bus.r_we     = r_we;
  assign bus.done     = done;
  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.elem_idx = idx;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench: sequencer with a synchronous-read memory model and an
// add datapath (A + B -> result register -> memory).
module tb_vec_mem_sequencer;

  logic clk;
  logic rst;

  vec_mem_sequencer_if #(.ADDR_W(16), .LEN_W(8)) bus ();

  vec_mem_sequencer #(.ADDR_W(16), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with synchronous read, preload port, and operand/result registers.
  logic [15:0] mem [0:65535];
  logic [15:0] rdata;
  logic [15:0] a_reg, b_reg, r_reg;
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= r_reg;
    rdata <= mem[bus.mem_addr];
    if (bus.a_we) a_reg <= rdata;
    if (bus.b_we) b_reg <= rdata;
    if (bus.r_we) r_reg <= a_reg + b_reg;
  end

  // Event monitor: pulse counters and write-address log.
  int we_cnt = 0, awe_cnt = 0, bwe_cnt = 0, rwe_cnt = 0, done_cnt = 0;
  logic [15:0] wr_q[$];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      we_cnt <= we_cnt + 1;
      wr_q.push_back(bus.mem_addr);
    end
    if (bus.a_we) awe_cnt <= awe_cnt + 1;
    if (bus.b_we) bwe_cnt <= bwe_cnt + 1;
    if (bus.r_we) rwe_cnt <= rwe_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] addr, input logic [15:0] data);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    step();
    pre_we   = 1'b0;
  endtask

  // Drives start for one cycle; on return we are one cycle after the start edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [7:0] n);
    bus.base_a = a;
    bus.base_b = b;
    bus.base_c = c;
    bus.vlen   = n;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  // Steps until done is visible; cyc is -1 if the budget runs out.
  task automatic wait_done(input int cyc0, input int limit, output int cyc);
    cyc = cyc0;
    while (!bus.done && cyc < limit) begin
      step();
      cyc++;
    end
    if (!bus.done) cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int d0, w0, a0, b0, r0, n0;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.base_c = '0;
    bus.vlen = '0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    step();
    step();

    // Reset state
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_enables", {bus.mem_we, bus.a_we, bus.b_we, bus.r_we}, 4'b0000);
    chk("rst_elem_idx", bus.elem_idx, 8'd0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b0;

    poke(16'h0010, 16'd1);  poke(16'h0011, 16'd2);  poke(16'h0012, 16'd3);
    poke(16'h0020, 16'd10); poke(16'h0021, 16'd20); poke(16'h0022, 16'd30);

    // vlen=3: address sequence, enables, done timing, C = A + B
    d0 = done_cnt; w0 = we_cnt;
    issue(16'h0010, 16'h0020, 16'h0030, 8'd3);
    chk("A_busy_rise", bus.busy, 1'b1);
    for (int e = 0; e < 3; e++) begin
      chk("A_rd_a_addr", bus.mem_addr, 16'h0010 + 16'(e));
      chk("A_elem_idx", bus.elem_idx, 8'(e));
      step();
      chk("A_rd_b_addr", bus.mem_addr, 16'h0020 + 16'(e));
      chk("A_rd_b_awe", bus.a_we, 1'b1);
      step();
      chk("A_ld_b_addr", bus.mem_addr, 16'h0020 + 16'(e));
      chk("A_ld_b_bwe", bus.b_we, 1'b1);
      step();
      chk("A_exec_rwe", bus.r_we, 1'b1);
      step();
      chk("A_wr_addr", bus.mem_addr, 16'h0030 + 16'(e));
      chk("A_wr_we", bus.mem_we, 1'b1);
      step();
    end
    chk("A_done_at_16", bus.done, 1'b1);
    chk("A_no_early_done", done_cnt, d0);
    step();
    chk("A_done_one_cycle", bus.done, 1'b0);
    chk("A_idle_busy", bus.busy, 1'b0);
    chk("A_idle_idx", bus.elem_idx, 8'd0);
    chk("A_we_pulses", we_cnt - w0, 3);
    chk("A_c0", mem[16'h0030], 16'd11);
    chk("A_c1", mem[16'h0031], 16'd22);
    chk("A_c2", mem[16'h0032], 16'd33);
    $display("op vlen=3 bases=10/20/30 done_cycle=16 C=%0d,%0d,%0d",
             mem[16'h0030], mem[16'h0031], mem[16'h0032]);

    // vlen=0: done after one cycle, no memory or register activity
    w0 = we_cnt; a0 = awe_cnt; b0 = bwe_cnt; r0 = rwe_cnt;
    issue(16'h0010, 16'h0020, 16'h0030, 8'd0);
    chk("Z_done_at_1", bus.done, 1'b1);
    chk("Z_busy", bus.busy, 1'b1);
    chk("Z_mem_addr", bus.mem_addr, 16'h0000);
    step();
    chk("Z_idle", bus.busy, 1'b0);
    chk("Z_enables", {32'(we_cnt - w0), 32'(awe_cnt - a0), 32'(bwe_cnt - b0), 32'(rwe_cnt - r0)} == '0, 1'b1);
    $display("op vlen=0 done_cycle=1");

    // Destination wrap: base_c=0xFFFF, vlen=2
    poke(16'h0100, 16'd5); poke(16'h0101, 16'd6);
    poke(16'h0200, 16'd7); poke(16'h0201, 16'd8);
    n0 = wr_q.size();
    issue(16'h0100, 16'h0200, 16'hFFFF, 8'd2);
    wait_done(1, 40, cyc);
    chk("W_done_cycle", cyc, 11);
    step();
    chk("W_write_count", wr_q.size() - n0, 2);
    if (wr_q.size() >= n0 + 2) begin
      chk("W_addr0", wr_q[n0], 16'hFFFF);
      chk("W_addr1", wr_q[n0 + 1], 16'h0000);
    end
    chk("W_data0", mem[16'hFFFF], 16'd12);
    chk("W_data1", mem[16'h0000], 16'd14);
    $display("op vlen=2 base_c=ffff done_cycle=%0d", cyc);

    // start during EXEC is ignored; start held through DONE is taken from IDLE
    poke(16'h0040, 16'd100); poke(16'h0041, 16'd200);
    poke(16'h0050, 16'd1);   poke(16'h0051, 16'd2);
    poke(16'h0070, 16'd3);   poke(16'h0080, 16'd4);
    issue(16'h0040, 16'h0050, 16'h0060, 8'd2);
    step(); step(); step();
    chk("S_exec", bus.r_we, 1'b1);
    bus.base_a = 16'h0400; bus.base_b = 16'h0500; bus.base_c = 16'h0600; bus.vlen = 8'd9;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("S_wr_addr_kept", bus.mem_addr, 16'h0060);
    step();
    chk("S_rd_a_e1", bus.mem_addr, 16'h0041);
    wait_done(6, 40, cyc);
    chk("S_done_cycle", cyc, 11);
    $display("op vlen=2 bases=40/50/60 with stray start done_cycle=%0d", cyc);
    bus.base_a = 16'h0070; bus.base_b = 16'h0080; bus.base_c = 16'h0090; bus.vlen = 8'd1;
    bus.start = 1'b1;
    step();
    chk("S_done_start_ignored", bus.busy, 1'b0);
    step();
    bus.start = 1'b0;
    chk("S_idle_start_taken", bus.busy, 1'b1);
    chk("S_new_rd_a", bus.mem_addr, 16'h0070);
    wait_done(1, 20, cyc);
    chk("S_new_done_cycle", cyc, 6);
    step();
    chk("S_c60", mem[16'h0060], 16'd101);
    chk("S_c61", mem[16'h0061], 16'd202);
    chk("S_c90", mem[16'h0090], 16'd7);
    $display("op vlen=1 bases=70/80/90 accepted from IDLE done_cycle=%0d", cyc);

    // Reset in RD_B of element 2 (vlen=4)
    issue(16'h0010, 16'h0020, 16'h0130, 8'd4);
    repeat (11) step();
    chk("R_pre_addr", bus.mem_addr, 16'h0022);
    chk("R_pre_awe", bus.a_we, 1'b1);
    chk("R_pre_idx", bus.elem_idx, 8'd2);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("R_enables", {bus.mem_we, bus.a_we, bus.b_we, bus.r_we}, 4'b0000);
    chk("R_busy", bus.busy, 1'b0);
    chk("R_idx", bus.elem_idx, 8'd0);
    chk("R_mem_addr", bus.mem_addr, 16'h0000);
    chk("R_done", bus.done, 1'b0);
    repeat (10) step();
    chk("R_no_done_pulse", done_cnt, d0);
    chk("R_still_idle", bus.busy, 1'b0);
    chk("R_partial_c0", mem[16'h0130], 16'd11);
    chk("R_partial_c1", mem[16'h0131], 16'd22);
    $display("op vlen=4 reset in element 2 partial C=%0d,%0d",
             mem[16'h0130], mem[16'h0131]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
